// File: rtl/dsp_fft_bitrev.sv
// Bit-reversal reorder stage: ping-pong frame buffer that turns
// bit-reversed DIF FFT output into a natural-order valid/ready stream.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   din, din_vld       bit-reversed samples from the FFT
//   din_busy           both banks full; samples presented now are dropped
//   dout, dout_vld     natural-order output stream
//   dout_rdy           consumer accepts dout this cycle
//   dout_last          last sample (index N-1) of a frame
//   ovf                sticky drop flag, cleared only by rst

module dsp_fft_bitrev #(
    parameter int DATA_W = 16,
    parameter int LOG2N  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_busy,
    output logic [DATA_W-1:0] dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_last,
    output logic              ovf
);

    localparam int N  = 1 << LOG2N;
    localparam int AW = LOG2N + 1;
    localparam int QD = 4;

    function automatic logic [LOG2N-1:0] bitrev(
        input logic [LOG2N-1:0] a
    );
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Both banks live in one array; the bank select is the address MSB.
    logic [DATA_W-1:0] mem [2*N];

    logic [1:0]       full;
    logic [1:0]       full_n;
    logic             wsel;
    logic             rsel;
    logic [LOG2N-1:0] wcnt;
    logic [LOG2N-1:0] rcnt;
    logic             ovf_q;

    logic             wr_en;
    logic             wr_done;
    logic             rd_issue;
    logic             rd_done;

    // Read pipeline: p1 = registered address, p2 = RAM data.
    logic             p1_vld;
    logic             p1_last;
    logic [AW-1:0]    p1_addr;
    logic             p2_vld;
    logic             p2_last;
    logic [DATA_W-1:0] p2_data;

    // Output queue: head is the output register, the rest is skid space.
    logic [DATA_W-1:0] q_data [QD];
    logic              q_last [QD];
    logic [1:0]        q_wp;
    logic [1:0]        q_rp;
    logic [2:0]        q_cnt;
    logic [2:0]        occ;
    logic              q_push;
    logic              q_pop;

    assign din_busy = full[0] & full[1];
    assign wr_en    = din_vld & ~din_busy;
    assign wr_done  = wr_en & (wcnt == {LOG2N{1'b1}});

    // Reads in flight count against the queue, so an issued read
    // always finds a slot and p1/p2 never need to stall.
    assign occ      = {2'b00, p1_vld} + {2'b00, p2_vld} + q_cnt;
    assign rd_issue = full[rsel] & (occ < 3'(QD));
    assign rd_done  = rd_issue & (rcnt == {LOG2N{1'b1}});

    assign q_push   = p2_vld;
    assign q_pop    = dout_vld & dout_rdy;

    assign dout      = q_data[q_rp];
    assign dout_vld  = (q_cnt != 3'd0);
    assign dout_last = dout_vld & q_last[q_rp];
    assign ovf       = ovf_q;

    // A write can only complete into the bank the reader is not on
    // when both updates land together, so set and clear never collide.
    always_comb begin
        full_n = full;
        if (wr_done) begin
            full_n[wsel] = 1'b1;
        end
        if (rd_done) begin
            full_n[rsel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wsel, wcnt}] <= din;
        end
        p2_data <= mem[p1_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 2'b00;
            wsel    <= 1'b0;
            rsel    <= 1'b0;
            wcnt    <= '0;
            rcnt    <= '0;
            ovf_q   <= 1'b0;
            p1_vld  <= 1'b0;
            p1_last <= 1'b0;
            p1_addr <= '0;
            p2_vld  <= 1'b0;
            p2_last <= 1'b0;
        end else begin
            full <= full_n;
            if (din_vld && din_busy) begin
                ovf_q <= 1'b1;
            end
            if (wr_en) begin
                wcnt <= wcnt + 1'b1;
                if (wr_done) begin
                    wsel <= ~wsel;
                end
            end
            if (rd_issue) begin
                rcnt <= rcnt + 1'b1;
                if (rd_done) begin
                    rsel <= ~rsel;
                end
            end
            p1_vld  <= rd_issue;
            p1_last <= rd_done;
            p1_addr <= {rsel, bitrev(rcnt)};
            p2_vld  <= p1_vld;
            p2_last <= p1_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_wp  <= '0;
            q_rp  <= '0;
            q_cnt <= '0;
            for (int i = 0; i < QD; i++) begin
                q_data[i] <= '0;
                q_last[i] <= 1'b0;
            end
        end else begin
            if (q_push) begin
                q_data[q_wp] <= p2_data;
                q_last[q_wp] <= p2_last;
                q_wp         <= q_wp + 1'b1;
            end
            if (q_pop) begin
                q_rp <= q_rp + 1'b1;
            end
            unique case ({q_push, q_pop})
                2'b10:   q_cnt <= q_cnt + 3'd1;
                2'b01:   q_cnt <= q_cnt - 3'd1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_fft_bitrev.sv
// Testbench for dsp_fft_bitrev: directed frames, drop/backpressure,
// mid-frame reset, random stalls, and a default-size frame.

module tb_dsp_fft_bitrev;

    localparam int DW = 16;
    localparam int N3 = 8;
    localparam int N8 = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [DW-1:0] din = '0;
    logic          din_vld = 1'b0;
    logic          din_busy;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          dout_rdy = 1'b1;
    logic          dout_last;
    logic          ovf;

    logic [DW-1:0] din8 = '0;
    logic          din_vld8 = 1'b0;
    logic          din_busy8;
    logic [DW-1:0] dout8;
    logic          dout_vld8;
    logic          dout_rdy8 = 1'b1;
    logic          dout_last8;
    logic          ovf8;

    always #5 clk = ~clk;

    dsp_fft_bitrev #(.DATA_W(DW), .LOG2N(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .din_busy  (din_busy),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_rdy  (dout_rdy),
        .dout_last (dout_last),
        .ovf       (ovf)
    );

    dsp_fft_bitrev #(.DATA_W(DW)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .din       (din8),
        .din_vld   (din_vld8),
        .din_busy  (din_busy8),
        .dout      (dout8),
        .dout_vld  (dout_vld8),
        .dout_rdy  (dout_rdy8),
        .dout_last (dout_last8),
        .ovf       (ovf8)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got,
                         input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Index reversal by plain arithmetic.
    function automatic int brev(input int x, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    exp_t exp_q[$];

    bit            mon_en = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    bit            prev_last = 1'b0;
    int            n_xfer = 0;
    int            frames_out = 0;
    int            first_cyc = -1;
    int            last_cyc = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_vld", dout_vld, 1);
                check("stall_dout", dout, prev_d);
                check("stall_last", dout_last, prev_last);
            end
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", dout_vld, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", dout, e.d);
                    check("dout_last", dout_last, e.last);
                    if (e.last) frames_out++;
                end
                n_xfer++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = dout_vld && !dout_rdy;
            prev_d     = dout;
            prev_last  = dout_last;
        end
    end

    task automatic push_frame(input int nat[N3]);
        for (int j = 0; j < N3; j++) begin
            exp_q.push_back('{d: DW'(nat[j]), last: (j == N3 - 1)});
        end
    endtask

    // Drives one frame in bit-reversed order; kept frames go to the
    // scoreboard, dropped ones must see din_busy on every sample.
    task automatic send_frame(input int nat[N3], input bit kept);
        if (kept) push_frame(nat);
        for (int k = 0; k < N3; k++) begin
            din     = DW'(nat[brev(k, 3)]);
            din_vld = 1'b1;
            if (kept) check("busy_while_writing", din_busy, 0);
            else      check("busy_on_drop", din_busy, 1);
            tick();
        end
        din_vld = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        tick();
        tick();
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        bit            last;
    } vec_t;

    vec_t tbl[N3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vin[N3];
        int nat[N3];
        int nat8[N8];
        int n0;
        int c;
        int sent;
        int k;
        int out0;

        vin = '{0, 4, 2, 6, 1, 5, 3, 7};
        for (int i = 0; i < N3; i++) begin
            tbl[i] = '{din: DW'(vin[i]), dout: DW'(i),
                       last: (i == N3 - 1)};
        end

        rst = 1'b1;
        repeat (3) tick();
        check("rst_dout", dout, 0);
        check("rst_vld", dout_vld, 0);
        check("rst_last", dout_last, 0);
        check("rst_busy", din_busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_vld8", dout_vld8, 0);
        rst = 1'b0;
        tick();

        dout_rdy = 1'b1;
        for (int i = 0; i < N3; i++) begin
            din     = tbl[i].din;
            din_vld = 1'b1;
            tick();
        end
        din_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lat_idle", dout_vld, 0);
            tick();
        end
        for (int i = 0; i < N3; i++) begin
            check("tbl_vld", dout_vld, 1);
            check("tbl_dout", dout, tbl[i].dout);
            check("tbl_last", dout_last, tbl[i].last);
            tick();
        end
        check("tbl_after_vld", dout_vld, 0);
        check("tbl_ovf", ovf, 0);
        check("tbl_busy", din_busy, 0);

        mon_en    = 1'b1;
        n0        = n_xfer;
        first_cyc = -1;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < N3; j++) nat[j] = f * N3 + j;
            send_frame(nat, 1'b1);
        end
        drain("stream_drain", 200);
        check("stream_count", n_xfer - n0, 32);
        check("stream_gapless", last_cyc - first_cyc, 31);

        dout_rdy = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < N3; j++) nat[j] = 100 + f * N3 + j;
            send_frame(nat, 1'b1);
        end
        check("busy_after_2", din_busy, 1);
        for (int j = 0; j < N3; j++) nat[j] = 900 + j;
        send_frame(nat, 1'b0);
        check("ovf_set", ovf, 1);
        repeat (4) tick();
        check("ovf_sticky", ovf, 1);
        n0       = n_xfer;
        dout_rdy = 1'b1;
        drain("drop_drain", 200);
        check("drop_count", n_xfer - n0, 16);

        for (int j = 0; j < N3; j++) nat[j] = 200 + j;
        send_frame(nat, 1'b1);
        for (int k2 = 0; k2 < 5; k2++) begin
            din     = DW'(300 + brev(k2, 3));
            din_vld = 1'b1;
            tick();
        end
        check("mid_output", dout_vld, 1);
        rst     = 1'b1;
        din_vld = 1'b0;
        tick();
        check("mrst_dout", dout, 0);
        check("mrst_vld", dout_vld, 0);
        check("mrst_last", dout_last, 0);
        check("mrst_busy", din_busy, 0);
        check("mrst_ovf", ovf, 0);
        exp_q.delete();
        rst = 1'b0;
        tick();
        check("idle_after_rst", dout_vld, 0);
        for (int j = 0; j < N3; j++) nat[j] = $urandom_range(0, 65535);
        send_frame(nat, 1'b1);
        drain("fresh_drain", 100);

        sent = 0;
        k    = 0;
        out0 = frames_out;
        c    = 0;
        while ((sent < 20 || exp_q.size() != 0) && c < 6000) begin
            dout_rdy = 1'($urandom_range(0, 1));
            if (sent < 20 && (k != 0 || (sent - (frames_out - out0)) < 2)
                && $urandom_range(0, 3) != 0) begin
                if (k == 0) begin
                    for (int j = 0; j < N3; j++)
                        nat[j] = $urandom_range(0, 65535);
                    push_frame(nat);
                end
                din     = DW'(nat[brev(k, 3)]);
                din_vld = 1'b1;
                check("rnd_busy", din_busy, 0);
                k++;
                if (k == N3) begin
                    k = 0;
                    sent++;
                end
            end else begin
                din_vld = 1'b0;
            end
            tick();
            c++;
        end
        din_vld  = 1'b0;
        dout_rdy = 1'b1;
        tick();
        check("rnd_frames", sent, 20);
        check("rnd_empty", exp_q.size(), 0);
        check("rnd_ovf", ovf, 0);

        for (int j = 0; j < N8; j++) nat8[j] = $urandom_range(0, 65535);
        for (int k2 = 0; k2 < N8; k2++) begin
            din8     = DW'(nat8[brev(k2, 8)]);
            din_vld8 = 1'b1;
            tick();
        end
        din_vld8 = 1'b0;
        c = 0;
        while (!dout_vld8 && c < 10) begin
            tick();
            c++;
        end
        check("lat8", c, 3);
        for (int j = 0; j < N8; j++) begin
            check("n8_vld", dout_vld8, 1);
            check("n8_dout", dout8, nat8[j]);
            check("n8_last", dout_last8, (j == N8 - 1));
            tick();
        end
        check("n8_idle", dout_vld8, 0);
        check("n8_ovf", ovf8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
